// File: rtl/vga_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, derived sync
// boundaries, blanking sentinels and the registered output bundle.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned CLK_DIV   = 2;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Sentinels lie outside any visible range so no sprite window can match.
    localparam logic [8:0] ROW_BLANK = 9'h1FF;
    localparam logic [9:0] COL_BLANK = 10'h3FF;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       line_start;
        logic       frame_start;
    } raster_t;

    localparam raster_t RASTER_RESET = '{
        row:         9'd0,
        col:         10'd0,
        hsync:       1'b1,
        vsync:       1'b1,
        video_on:    1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel clock-enable: a registered pulse every CLK_DIV clocks while enabled.
module pixel_tick_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q, div_d;
    logic         tick_q;

    always_comb begin
        div_d = div_q;
        if (en_i) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == DIV_LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: h/v counters paced by a pixel clock-enable, with all
// coordinates, syncs and strobes registered on the same edge as the counters.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK,
    parameter int unsigned CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (V_VISIBLE > 511) || (CLK_DIV < 2)) begin : g_cfg_check
        $error("vga_scan_gen: timing parameters exceed counter widths");
    end

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_LO  = 11'(HS_START);
    localparam logic [10:0] HS_HI  = 11'(HS_END);
    localparam logic [10:0] VS_LO  = 11'(VS_START);
    localparam logic [10:0] VS_HI  = 11'(VS_END);

    logic        first_q;
    logic        pix_adv;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [7:0]  fc_q, fc_d;
    logic        line_wrap, frame_wrap;
    logic [10:0] h_ext, v_ext;
    raster_t     out_q, out_d;

    // The divider is held for the load cycle after reset so pixel (0,0)
    // still lasts a full CLK_DIV clocks.
    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en_i   (!first_q),
        .tick_o (pix_adv)
    );

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        fc_d       = fc_q;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (pix_adv) begin
            if (h_q == H_LAST) begin
                h_d       = '0;
                line_wrap = 1'b1;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                    fc_d       = fc_q + 8'd1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Decode the next counter values so outputs land with the counters.
        h_ext             = {1'b0, h_d};
        v_ext             = {1'b0, v_d};
        out_d             = RASTER_RESET;
        out_d.col         = (h_ext < H_VIS) ? h_d : COL_BLANK;
        out_d.row         = (v_ext < V_VIS) ? v_d[8:0] : ROW_BLANK;
        out_d.hsync       = !((h_ext >= HS_LO) && (h_ext < HS_HI));
        out_d.vsync       = !((v_ext >= VS_LO) && (v_ext < VS_HI));
        out_d.video_on    = (h_ext < H_VIS) && (v_ext < V_VIS);
        out_d.line_start  = first_q || line_wrap;
        out_d.frame_start = first_q || frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= 1'b1;
            h_q     <= '0;
            v_q     <= '0;
            fc_q    <= '0;
            out_q   <= RASTER_RESET;
        end else begin
            first_q <= 1'b0;
            h_q     <= h_d;
            v_q     <= v_d;
            fc_q    <= fc_d;
            out_q   <= out_d;
        end
    end

    assign row         = out_q.row;
    assign col         = out_q.col;
    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign video_on    = out_q.video_on;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;
    assign pix_tick    = pix_adv;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default-timing instance and a tiny-timing instance
// (full frames and the 255->0 frame_count wrap), both under random resets.
module tb_vga_scan_gen;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    localparam int NCYC = 34500;
    // Small configuration: 7 pixels x 6 lines, 3 clks per pixel -> 126 clks/frame.
    localparam int B_HV = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_DIV = 3;
    localparam int B_FRAME = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB) * B_DIV;

    logic clk;
    logic rst_a, rst_b;
    logic stim_done;

    logic [8:0] a_row, b_row;
    logic [9:0] a_col, b_col;
    logic a_hs, a_vs, a_von, a_tick, a_ls, a_fs;
    logic b_hs, b_vs, b_von, b_tick, b_ls, b_fs;
    logic [7:0] a_fc, b_fc;

    obs_t qa[$];
    obs_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;

    vga_scan_gen u_dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .row         (a_row),
        .col         (a_col),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .video_on    (a_von),
        .pix_tick    (a_tick),
        .line_start  (a_ls),
        .frame_start (a_fs),
        .frame_count (a_fc)
    );

    vga_scan_gen #(
        .H_VISIBLE (B_HV),
        .H_FRONT   (B_HF),
        .H_SYNC    (B_HS),
        .H_BACK    (B_HB),
        .V_VISIBLE (B_VV),
        .V_FRONT   (B_VF),
        .V_SYNC    (B_VS),
        .V_BACK    (B_VB),
        .CLK_DIV   (B_DIV)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .row         (b_row),
        .col         (b_col),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .video_on    (b_von),
        .pix_tick    (b_tick),
        .line_start  (b_ls),
        .frame_start (b_fs),
        .frame_count (b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: n = clocks since reset release (n=0 is the first clk after
    // release, -1 while in reset); the raster position is plain arithmetic on n.
    function automatic obs_t model(input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input int dv, input int n);
        obs_t o;
        int ht, vt, p, ph, h, ln, v, fr;
        if (n < 0) begin
            o = '0;
            o.hs = 1'b1;
            o.vs = 1'b1;
            return o;
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = n / dv;
        ph = n % dv;
        h  = p % ht;
        ln = p / ht;
        v  = ln % vt;
        fr = ln / vt;
        o.col  = (h < hv) ? 10'(h) : 10'h3FF;
        o.row  = (v < vv) ? 9'(v) : 9'h1FF;
        o.hs   = !((h >= hv + hf) && (h < hv + hf + hsw));
        o.vs   = !((v >= vv + vf) && (v < vv + vf + vsw));
        o.von  = (h < hv) && (v < vv);
        o.tick = (ph == dv - 1);
        o.ls   = (ph == 0) && (h == 0);
        o.fs   = o.ls && (v == 0);
        o.fc   = 8'(fr % 256);
        return o;
    endfunction

    // Stimulus: choose resets for the coming edge and queue the expected outputs.
    initial begin
        int n_a, n_b, left_a, left_b, a_force_at, b_reset_at;
        bit a_forced, b_done;
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        stim_done  = 1'b0;
        n_a        = -1;
        n_b        = -1;
        left_a     = 3;
        left_b     = 3 + int'($urandom_range(0, 2));
        a_forced   = 1'b0;
        b_done     = 1'b0;
        a_force_at = int'($urandom_range(6000, 9000));
        b_reset_at = 257 * B_FRAME + int'($urandom_range(10, 100));
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (left_a == 0 && n_a > 3300) begin
                if (!a_forced && n_a >= a_force_at) begin
                    left_a   = 1;
                    a_forced = 1'b1;
                end else if ($urandom_range(0, 3999) == 0) begin
                    left_a = int'($urandom_range(1, 3));
                end
            end
            if (left_b == 0 && !b_done && n_b >= b_reset_at) begin
                left_b = 1;
                b_done = 1'b1;
            end
            rst_a = (left_a > 0);
            rst_b = (left_b > 0);
            if (left_a > 0) left_a--;
            if (left_b > 0) left_b--;
            n_a = rst_a ? -1 : n_a + 1;
            n_b = rst_b ? -1 : n_b + 1;
            qa.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 2, n_a));
            qb.push_back(model(B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_DIV, n_b));
        end
        @(negedge clk);
        stim_done = 1'b1;
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    obs_t ea, eb, aa, ab;
    int   cyc          = 0;
    int   a_ls_cnt     = 0;
    int   a_last_ls    = 0;
    int   a_hs_low     = 0;
    int   a_blank      = 0;
    int   a_prev_hs    = 1;
    int   m_period     = -1;
    int   m_hs_low     = -1;
    int   m_blank      = -1;
    int   m_hs_fall    = -1;
    int   b_saw_wrap   = 0;
    logic [7:0] b_prev_fc = '0;

    // Monitor: pop and compare every clk the DUTs present outputs.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            aa = {a_row, a_col, a_hs, a_vs, a_von, a_tick, a_ls, a_fs, a_fc};
            n_checks++;
            if (aa !== ea) begin
                n_fail++;
                $display("FAIL scan_a cyc=%0d got=%h expected=%h", cyc, aa, ea);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            ab = {b_row, b_col, b_hs, b_vs, b_von, b_tick, b_ls, b_fs, b_fc};
            n_checks++;
            if (ab !== eb) begin
                n_fail++;
                $display("FAIL scan_b cyc=%0d got=%h expected=%h", cyc, ab, eb);
            end
        end

        // First full line of instance A, measured directly from its outputs.
        if (a_ls === 1'b1) begin
            if (a_ls_cnt == 1) begin
                m_period = cyc - a_last_ls;
                m_hs_low = a_hs_low;
                m_blank  = a_blank;
            end
            a_ls_cnt++;
            a_last_ls = cyc;
            a_hs_low  = 0;
            a_blank   = 0;
        end
        if (a_hs === 1'b0) a_hs_low++;
        if (a_col === 10'h3FF) a_blank++;
        if (a_ls_cnt == 1 && a_hs === 1'b0 && a_prev_hs == 1) m_hs_fall = cyc - a_last_ls;
        a_prev_hs = (a_hs === 1'b0) ? 0 : 1;

        if (b_fs === 1'b1 && b_prev_fc == 8'hFF && b_fc == 8'h00) b_saw_wrap = 1;
        b_prev_fc = b_fc;

        if (stim_done && qa.size() == 0 && qb.size() == 0) begin
            check_int("line_period_clks", m_period, 1600);
            check_int("hsync_low_clks", m_hs_low, 192);
            check_int("hsync_fall_offset", m_hs_fall, 1312);
            check_int("col_blank_clks", m_blank, 320);
            check_int("frame_count_wrap_seen", b_saw_wrap, 1);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #(NCYC * 10 + 20000);
        $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
